// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage. It holds the fetch PC, selects the
//               next PC, checks the target for misalignment and holds the
//               IF/ID pipeline register. A two-state FSM (RUN/HALT) stops
//               fetching after a misaligned target until reset.
// Ports       : clk, reset          - clock, async active-high reset
//               stall_f, flush_d    - hold PC + IF/ID / bubble IF/ID
//               pcsrc               - next-PC select (seq/branch/jump/jr)
//               pcplus4_in          - PC+4 from the external adder
//               pcbranch, jtarget,
//               jr_target           - redirect targets
//               instr_f             - instruction word at pc_f
//               pc_f                - fetch PC
//               instr_d, pcplus4_d,
//               valid_d             - IF/ID register contents
//               err_f               - sticky misaligned-target error
//               halted              - FSM is in HALT
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        flush_d,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] pcplus4_in,
    input  logic [31:0] pcbranch,
    input  logic [25:0] jtarget,
    input  logic [31:0] jr_target,
    input  logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pcplus4_d,
    output logic        valid_d,
    output logic        err_f,
    output logic        halted
);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    localparam logic [31:0] c_NOP = 32'h0000_0000;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr_d;
    logic [31:0] r_pcplus4_d;
    logic        r_valid_d;
    logic        r_err;
    logic        r_halted;

    logic [31:0] w_next_pc;
    logic        w_misaligned;

    always_comb begin
        w_next_pc = pcplus4_in;
        case (pcsrc)
            2'b00:   w_next_pc = pcplus4_in;
            2'b01:   w_next_pc = pcbranch;
            2'b10:   w_next_pc = {pcplus4_in[31:28], jtarget, 2'b00};
            default: w_next_pc = jr_target;
        endcase
    end

    assign w_misaligned = (w_next_pc[1:0] != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_RUN;
            r_pc        <= RESET_PC;
            r_instr_d   <= c_NOP;
            r_pcplus4_d <= 32'h0;
            r_valid_d   <= 1'b0;
            r_err       <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            // PC / FSM. A stall suppresses both the PC update and the
            // alignment check, so a pending redirect is simply not applied.
            case (r_state)
                S_RUN: begin
                    if (!stall_f) begin
                        if (w_misaligned) begin
                            r_err    <= 1'b1;
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_pc <= w_next_pc;
                        end
                    end
                end
                default: begin
                    // HALT: everything frozen until reset.
                    r_state  <= S_HALT;
                    r_halted <= 1'b1;
                end
            endcase

            // IF/ID register: flush beats stall; a misaligned fetch in RUN
            // and every cycle in HALT produce a bubble.
            if (flush_d) begin
                r_instr_d   <= c_NOP;
                r_pcplus4_d <= 32'h0;
                r_valid_d   <= 1'b0;
            end else if (stall_f) begin
                r_instr_d   <= r_instr_d;
                r_pcplus4_d <= r_pcplus4_d;
                r_valid_d   <= r_valid_d;
            end else if (r_state == S_RUN && !w_misaligned) begin
                r_instr_d   <= instr_f;
                r_pcplus4_d <= pcplus4_in;
                r_valid_d   <= 1'b1;
            end else begin
                r_instr_d   <= c_NOP;
                r_pcplus4_d <= 32'h0;
                r_valid_d   <= 1'b0;
            end
        end
    end

    assign pc_f      = r_pc;
    assign instr_d   = r_instr_d;
    assign pcplus4_d = r_pcplus4_d;
    assign valid_d   = r_valid_d;
    assign err_f     = r_err;
    assign halted    = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. A behavioural model of
//               the fetch stage is compared against the DUT every cycle,
//               with directed scenarios followed by random stimulus. A
//               second instance with RESET_PC=FFFF_FFFC covers wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall_f = 1'b0;
    logic        flush_d = 1'b0;
    logic [1:0]  pcsrc = 2'b00;
    logic [31:0] pcbranch = 32'h0;
    logic [25:0] jtarget = 26'h0;
    logic [31:0] jr_target = 32'h0;
    logic [31:0] pcplus4_in;
    logic [31:0] instr_f;
    logic [31:0] pc_f, instr_d, pcplus4_d;
    logic        valid_d, err_f, halted;

    // wrap-around instance
    logic        rst_w = 1'b0;
    logic [31:0] w_pc, w_instr_d, w_pcplus4_d, w_pcplus4_in, w_instr_f;
    logic        w_valid_d, w_err, w_halted;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    // Instruction memory contents: a fixed hash of the address.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0001;
    endfunction

    // Environment: external adder and instruction memory fed by pc_f.
    assign pcplus4_in   = pc_f + 32'd4;
    assign instr_f      = imem(pc_f);
    assign w_pcplus4_in = w_pc + 32'd4;
    assign w_instr_f    = imem(w_pc);

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .stall_f(stall_f), .flush_d(flush_d),
        .pcsrc(pcsrc), .pcplus4_in(pcplus4_in), .pcbranch(pcbranch),
        .jtarget(jtarget), .jr_target(jr_target), .instr_f(instr_f),
        .pc_f(pc_f), .instr_d(instr_d), .pcplus4_d(pcplus4_d),
        .valid_d(valid_d), .err_f(err_f), .halted(halted)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(rst_w), .stall_f(1'b0), .flush_d(1'b0),
        .pcsrc(2'b00), .pcplus4_in(w_pcplus4_in), .pcbranch(32'h0),
        .jtarget(26'h0), .jr_target(32'h0), .instr_f(w_instr_f),
        .pc_f(w_pc), .instr_d(w_instr_d), .pcplus4_d(w_pcplus4_d),
        .valid_d(w_valid_d), .err_f(w_err), .halted(w_halted)
    );

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_instr, m_p4;
    bit          m_valid, m_err, m_halt;

    function automatic logic [31:0] model_next(input logic [1:0] sel,
                                               input logic [31:0] pc);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        case (sel)
            2'd0:    return p4;
            2'd1:    return pcbranch;
            2'd2:    return {p4[31:28], jtarget, 2'b00};
            default: return jr_target;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc <= 32'h0; m_instr <= 32'h0; m_p4 <= 32'h0;
            m_valid <= 1'b0; m_err <= 1'b0; m_halt <= 1'b0;
        end else if (m_halt) begin
            m_instr <= 32'h0; m_p4 <= 32'h0; m_valid <= 1'b0;
        end else if (stall_f) begin
            if (flush_d) begin
                m_instr <= 32'h0; m_p4 <= 32'h0; m_valid <= 1'b0;
            end
        end else if (model_next(pcsrc, m_pc) % 4 != 0) begin
            m_err <= 1'b1; m_halt <= 1'b1;
            m_instr <= 32'h0; m_p4 <= 32'h0; m_valid <= 1'b0;
        end else begin
            m_pc <= model_next(pcsrc, m_pc);
            if (flush_d) begin
                m_instr <= 32'h0; m_p4 <= 32'h0; m_valid <= 1'b0;
            end else begin
                m_instr <= imem(m_pc); m_p4 <= m_pc + 32'd4; m_valid <= 1'b1;
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("m_pc_f",      pc_f,      m_pc);
            cmp("m_instr_d",   instr_d,   m_instr);
            cmp("m_pcplus4_d", pcplus4_d, m_p4);
            cmp("m_valid_d",   {31'h0, valid_d}, {31'h0, m_valid});
            cmp("m_err_f",     {31'h0, err_f},   {31'h0, m_err});
            cmp("m_halted",    {31'h0, halted},  {31'h0, m_halt});
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    function automatic logic [31:0] rnd_target();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(11) != 0) t[1:0] = 2'b00;
        return t;
    endfunction

    initial begin
        // reset both instances
        #1 reset = 1'b1; rst_w = 1'b1;
        chk_en = 1'b1;
        #1;
        cmp("rst_pc",     pc_f, 32'h0);
        cmp("rst_instr",  instr_d, 32'h0);
        cmp("rst_valid",  {31'h0, valid_d}, 32'h0);
        cmp("rst_err",    {31'h0, err_f}, 32'h0);
        cmp("rst_halted", {31'h0, halted}, 32'h0);
        cmp("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
        step();
        reset = 1'b0; rst_w = 1'b0;

        // sequential fetch
        step();
        cmp("seq_pc4",    pc_f, 32'h4);
        cmp("seq_instr0", instr_d, 32'hA5A5_0001);
        cmp("seq_p4_0",   pcplus4_d, 32'h4);
        cmp("seq_valid",  {31'h0, valid_d}, 32'h1);
        cmp("wrap_pc",    w_pc, 32'h0);
        cmp("wrap_err",   {31'h0, w_err}, 32'h0);
        cmp("wrap_p4_d",  w_pcplus4_d, 32'h0);
        cmp("wrap_valid", {31'h0, w_valid_d}, 32'h1);
        rst_w = 1'b1;
        step();
        cmp("seq_pc8", pc_f, 32'h8);

        // stall for two edges
        stall_f = 1'b1;
        step();
        step();
        cmp("stall_pc",    pc_f, 32'h8);
        cmp("stall_instr", instr_d, imem(32'h4));
        cmp("stall_p4",    pcplus4_d, 32'h8);
        // stall + flush
        flush_d = 1'b1;
        step();
        cmp("sf_pc",    pc_f, 32'h8);
        cmp("sf_instr", instr_d, 32'h0);
        cmp("sf_valid", {31'h0, valid_d}, 32'h0);
        stall_f = 1'b0; flush_d = 1'b0;
        step();
        cmp("seq_pcC",    pc_f, 32'hC);
        cmp("seq_instr8", instr_d, imem(32'h8));

        // redirects
        pcsrc = 2'b01; pcbranch = 32'h100;
        step();
        cmp("br_pc", pc_f, 32'h100);
        pcsrc = 2'b10; jtarget = 26'h40;   // pcplus4_in is 0x104 here
        step();
        cmp("j_pc", pc_f, 32'h100);
        pcsrc = 2'b11; jr_target = 32'h200;
        step();
        cmp("jr_pc", pc_f, 32'h200);

        // misaligned target
        jr_target = 32'h202;
        step();
        cmp("mis_err",    {31'h0, err_f}, 32'h1);
        cmp("mis_halted", {31'h0, halted}, 32'h1);
        cmp("mis_pc",     pc_f, 32'h200);
        cmp("mis_valid",  {31'h0, valid_d}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            pcsrc = 2'($urandom); stall_f = 1'($urandom); flush_d = 1'($urandom);
            jr_target = 32'h300;
            step();
            cmp("halt_pc",    pc_f, 32'h200);
            cmp("halt_valid", {31'h0, valid_d}, 32'h0);
            cmp("halt_err",   {31'h0, err_f}, 32'h1);
        end

        // mid-clock reset pulse
        stall_f = 1'b0; flush_d = 1'b0; pcsrc = 2'b00;
        reset = 1'b1;
        #1;
        cmp("rp_pc",     pc_f, 32'h0);
        cmp("rp_err",    {31'h0, err_f}, 32'h0);
        cmp("rp_halted", {31'h0, halted}, 32'h0);
        #1 reset = 1'b0;
        step();
        cmp("rp_fetch", pc_f, 32'h4);

        // random phase
        for (int i = 0; i < 500; i++) begin
            if (reset) reset = 1'b0;
            else if ($urandom_range(39) == 0 || (m_halt && $urandom_range(3) == 0))
                reset = 1'b1;
            stall_f   = ($urandom_range(4) == 0);
            flush_d   = ($urandom_range(6) == 0);
            pcsrc     = 2'($urandom);
            pcbranch  = rnd_target();
            jr_target = rnd_target();
            jtarget   = 26'($urandom);
            step();
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
